// File: rtl/traffic_lamp_monitor.sv
// Conflict / invalid-lamp / colour-sequence monitor for a two-direction signal controller.
// Optional short-yellow check (fault code 4) is compiled in with `define MON_YMIN_CHECK_EN.
module traffic_lamp_monitor #(
  parameter int CONF_CYC = 2,
  parameter int BAD_CYC  = 4,
  parameter int YMIN     = 3,
  parameter int CNT_W    = 4
) (
  input  logic       CK,
  input  logic       CLRN,
  input  logic       GRN1,
  input  logic       YLW1,
  input  logic       RED1,
  input  logic       GRN2,
  input  logic       YLW2,
  input  logic       RED2,
  input  logic       ACK,
  output logic       FAULT,
  output logic [2:0] FCODE,
  output logic       FDIR,
  output logic       ALLRED
);

  typedef enum logic [1:0] {LAMP_R, LAMP_Y, LAMP_G, LAMP_X} lamp_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CONF_TH = cnt_t'(CONF_CYC);
  localparam cnt_t BAD_TH  = cnt_t'(BAD_CYC);

  function automatic cnt_t sat_inc(input cnt_t c);
    return (&c) ? c : c + cnt_t'(1);
  endfunction

  logic [1:0] grn, ylw, red;
  assign grn = {GRN2, GRN1};
  assign ylw = {YLW2, YLW1};
  assign red = {RED2, RED1};

  lamp_t      dec       [2];
  lamp_t      prev_reg  [2];
  lamp_t      prev_next [2];
  cnt_t       bad_reg   [2];
  cnt_t       bad_next  [2];
  logic [1:0] valid, changed, legal, bad_err, seq_err, short_err;

  cnt_t       conf_reg, conf_next;
  logic       conflict, conf_err;
  logic       fault_reg, fdir_reg, allred_reg;
  logic [2:0] fcode_reg;
  logic       both_red, ack_ok;
  logic       det, det_dir;
  logic [2:0] det_code;

`ifdef MON_YMIN_CHECK_EN
  localparam cnt_t YMIN_TH = cnt_t'(YMIN);
  cnt_t ycnt_reg  [2];
  cnt_t ycnt_next [2];
`else
  logic unused_ymin;
  assign unused_ymin = (YMIN != 0);
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dir
      assign dec[gi] = ({grn[gi], ylw[gi], red[gi]} == 3'b001) ? LAMP_R :
                       ({grn[gi], ylw[gi], red[gi]} == 3'b010) ? LAMP_Y :
                       ({grn[gi], ylw[gi], red[gi]} == 3'b100) ? LAMP_G : LAMP_X;
      assign valid[gi]     = (dec[gi] != LAMP_X);
      assign bad_next[gi]  = valid[gi] ? '0 : sat_inc(bad_reg[gi]);
      assign bad_err[gi]   = !valid[gi] && (bad_next[gi] >= BAD_TH);
      assign prev_next[gi] = valid[gi] ? dec[gi] : prev_reg[gi];
      assign changed[gi]   = valid[gi] && (dec[gi] != prev_reg[gi]);
      assign legal[gi]     = (prev_reg[gi] == LAMP_G && dec[gi] == LAMP_Y) ||
                             (prev_reg[gi] == LAMP_Y && dec[gi] == LAMP_R) ||
                             (prev_reg[gi] == LAMP_R && dec[gi] == LAMP_G);
      assign seq_err[gi]   = changed[gi] && !legal[gi];
`ifdef MON_YMIN_CHECK_EN
      assign ycnt_next[gi] = (dec[gi] == LAMP_Y) ? sat_inc(ycnt_reg[gi]) :
                             (valid[gi] ? '0 : ycnt_reg[gi]);
      assign short_err[gi] = changed[gi] && (prev_reg[gi] == LAMP_Y) &&
                             (dec[gi] == LAMP_R) && (ycnt_reg[gi] < YMIN_TH);
`else
      assign short_err[gi] = 1'b0;
`endif
    end
  endgenerate

  // A direction is "not red" exactly when any of its green/yellow lamps is lit.
  assign conflict  = (GRN1 | YLW1) & (GRN2 | YLW2);
  assign conf_next = conflict ? sat_inc(conf_reg) : '0;
  assign conf_err  = conflict && (conf_next >= CONF_TH);

  assign both_red = (dec[0] == LAMP_R) && (dec[1] == LAMP_R);
  assign ack_ok   = ACK && both_red;

  always_comb begin
    det      = 1'b1;
    det_code = 3'd0;
    det_dir  = 1'b0;
    if (conf_err)          det_code = 3'd1;
    else if (bad_err[0])   det_code = 3'd2;
    else if (bad_err[1])   begin det_code = 3'd2; det_dir = 1'b1; end
    else if (seq_err[0])   det_code = 3'd3;
    else if (seq_err[1])   begin det_code = 3'd3; det_dir = 1'b1; end
    else if (short_err[0]) det_code = 3'd4;
    else if (short_err[1]) begin det_code = 3'd4; det_dir = 1'b1; end
    else                   det = 1'b0;
  end

  always_ff @(posedge CK or negedge CLRN) begin
    if (!CLRN) begin
      fault_reg  <= 1'b0;
      fcode_reg  <= 3'd0;
      fdir_reg   <= 1'b0;
      allred_reg <= 1'b0;
      conf_reg   <= '0;
      for (int i = 0; i < 2; i++) begin
        prev_reg[i] <= LAMP_R;
        bad_reg[i]  <= '0;
`ifdef MON_YMIN_CHECK_EN
        ycnt_reg[i] <= '0;
`endif
      end
    end else begin
      allred_reg <= both_red;
      if (ack_ok) begin
        fault_reg <= 1'b0;
        fcode_reg <= 3'd0;
        fdir_reg  <= 1'b0;
        conf_reg  <= '0;
        for (int i = 0; i < 2; i++) begin
          prev_reg[i] <= LAMP_R;
          bad_reg[i]  <= '0;
`ifdef MON_YMIN_CHECK_EN
          ycnt_reg[i] <= '0;
`endif
        end
      end else begin
        conf_reg <= conf_next;
        for (int i = 0; i < 2; i++) begin
          prev_reg[i] <= prev_next[i];
          bad_reg[i]  <= bad_next[i];
`ifdef MON_YMIN_CHECK_EN
          ycnt_reg[i] <= ycnt_next[i];
`endif
        end
        if (!fault_reg && det) begin
          fault_reg <= 1'b1;
          fcode_reg <= det_code;
          fdir_reg  <= det_dir;
        end
      end
    end
  end

  assign FAULT  = fault_reg;
  assign FCODE  = fcode_reg;
  assign FDIR   = fdir_reg;
  assign ALLRED = allred_reg;

endmodule

// File: doc/traffic_lamp_monitor.md
# traffic_lamp_monitor

- Independent conflict monitor on the receiving end of the two-direction traffic-light controller's lamp outputs: GRN1/YLW1/RED1 and GRN2/YLW2/RED2.
- Samples the six lamp lines every clock and checks for cross-direction conflicts, invalid lamp combinations, illegal colour sequences and, when configured, short yellows.
- Latches the first fault with a code; the fault output is the system's flash/shutdown request.
- Sits beside the controller and shares its clock.

## Interface
Parameters:
- CONF_CYC, 2 — consecutive sampled cycles a conflict must persist before it latches (1..2^CNT_W-1).
- BAD_CYC, 4 — consecutive sampled cycles an invalid lamp combination must persist before it latches.
- YMIN, 3 — minimum number of sampled yellow cycles before red is allowed.
- CNT_W, 4 — width of every persistence/yellow counter.

Ports:
- CK  in  1  clock, rising edge.
- CLRN  in  1  reset, asynchronous assert, active-low.
- GRN1, YLW1, RED1  in  1 each  direction-1 lamps.
- GRN2, YLW2, RED2  in  1 each  direction-2 lamps.
- ACK  in  1  operator fault-clear request.
- FAULT  out  1  latched fault / flash request.
- FCODE  out  3  latched fault code: 0 none, 1 conflict, 2 invalid lamps, 3 illegal sequence, 4 short yellow.
- FDIR  out  1  direction of latched fault (0 = dir1, 1 = dir2; always 0 for code 1).
- ALLRED  out  1  registered: both directions sampled valid red.

## Operation
- Decode per direction each cycle: R = only red lit, Y = only yellow lit, G = only green lit. Any other combination (none lit, or more than one lit) is X.
- prev1/prev2 hold the last valid (non-X) state per direction. Reset value is R. X samples do not update them.
- **Conflict:** both directions decoded non-R, where X counts as non-R only if some green or yellow is lit. A saturating counter increments on each such sample and clears on any sample without conflict. Fault code 1 when the counter reaches CONF_CYC.
- **Invalid:** one counter per direction, incremented on X samples and cleared on any valid sample. Fault code 2 when a counter reaches BAD_CYC.
- **Sequence:** on a valid sample that differs from prev, only G→Y, Y→R and R→G are legal. Any other change raises code 3 immediately.
- **Short yellow:** per-direction yellow counter, incremented (saturating) on each Y sample and cleared on each non-Y valid sample. A Y→R change with counter < YMIN raises code 4 in the same cycle. Compiled in only with the macro (see Configuration).
- **Priority** among detections in the same cycle: code 1 > 2 > 3 > 4, then dir1 over dir2.
- **Latching:** while FAULT=1, no new detection changes FCODE/FDIR. Decoding, prev tracking and counters keep running.
- **ACK:** takes effect at an edge only when that cycle samples both directions as valid R. It then clears FAULT, FCODE, FDIR and all counters, and sets prev1 = prev2 = R. ACK with any other lamp state is ignored.
- ACK coinciding with a new detection: clear wins. Counters restart from 0.

## Timing
- Reset (CLRN=0, asynchronous): FAULT=0, FCODE=0, FDIR=0, ALLRED=0, all counters 0, prev1 = prev2 = R.
- The first edge after CLRN rises samples normally.
- All outputs are registered.
- Codes 3 and 4: the detecting edge sets FAULT, visible one cycle after the offending sample.
- Code 1: conflict sampled at edges k..k+CONF_CYC-1 sets FAULT at edge k+CONF_CYC-1.
- Code 2: invalid combination sampled at edges k..k+BAD_CYC-1 sets FAULT at edge k+BAD_CYC-1.
- A one-sample gap in a persistence condition restarts that count from zero.
- Counters saturate at 2^CNT_W-1. There is no wrap-around.
- ALLRED follows the lamp inputs with one-cycle latency, independent of FAULT.

## Configuration
- MON_YMIN_CHECK_EN defined: yellow counters present and code 4 is produced as described.
- MON_YMIN_CHECK_EN undefined: no yellow counters, YMIN unused, code 4 never produced. A Y→R change is always legal.

## Test plan
- **Reset/idle:** hold CLRN=0, then release with both directions red for 10 cycles → FAULT=0, FCODE=0, ALLRED=1 from the second cycle.
- **Legal cycle:** dir1 R→G(5)→Y(3)→R with dir2 red, then dir2 the same → no fault with CONF_CYC=2, YMIN=3.
- **Conflict persistence:** GRN1 and GRN2 both lit for 1 cycle → no fault. Both lit for 2 consecutive cycles → FAULT=1, FCODE=1, FDIR=0 after the second edge.
- **Sequence:** dir2 G then directly R → FAULT=1, FCODE=3, FDIR=1 one cycle later. A later dark dir1 for 6 cycles → FCODE stays 3.
- **Short yellow (macro on):** dir1 Y for 2 cycles then R → FCODE=4, FDIR=0. With the macro off, the same stimulus gives FAULT=0.
- **ACK gating:** with FCODE=2 latched, ACK while dir1 is green → ignored. ACK while both red → FAULT=0, FCODE=0 next cycle. Assert CLRN=0 mid-fault → outputs clear immediately.
